// File: rtl/dds_pkg.sv
// Shared constants for the SPI command decoder: opcodes,
// payload lengths, decoder state encoding.
package dds_pkg;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_SET_FREQ = 4'h1;
    localparam logic [3:0] OP_SET_ENV  = 4'h2;
    localparam logic [3:0] OP_SET_WAVE = 4'h3;

    localparam logic [1:0] PAY_LEN_NOP  = 2'd0;
    localparam logic [1:0] PAY_LEN_FREQ = 2'd2;
    localparam logic [1:0] PAY_LEN_ENV  = 2'd1;
    localparam logic [1:0] PAY_LEN_WAVE = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAY1 = 2'd1,
        PAY2 = 2'd2
    } state_t;

    function automatic logic op_valid(input logic [3:0] op);
        return (op <= OP_SET_WAVE);
    endfunction

    function automatic logic [1:0] pay_len(input logic [3:0] op);
        case (op)
            OP_NOP:      return PAY_LEN_NOP;
            OP_SET_FREQ: return PAY_LEN_FREQ;
            OP_SET_ENV:  return PAY_LEN_ENV;
            OP_SET_WAVE: return PAY_LEN_WAVE;
            default:     return PAY_LEN_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input,
// with a configurable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns the spi_slave byte stream into per-voice frequency and
// envelope registers plus a global waveform select.
module spi_cmd_decoder
    import dds_pkg::*;
#(
    parameter int         NUM_VOICES     = 8,
    parameter logic [2:0] WAVE_SEL_RESET = 3'd1,
    parameter int         ERR_CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_ready,
    input  logic                    spi_nss,
    output logic [16*NUM_VOICES-1:0] freq_bus,
    output logic [8*NUM_VOICES-1:0]  env_bus,
    output logic [2:0]              wave_sel,
    output logic [NUM_VOICES-1:0]   freq_upd,
    output logic [NUM_VOICES-1:0]   env_upd,
    output logic [ERR_CNT_W-1:0]    err_cnt,
    output logic                    busy
);

    state_t                   r_state;
    logic [3:0]               r_op;
    logic [2:0]               r_voice;
    logic [7:0]               r_hi;
    logic                     r_nss_d;
    logic                     r_rx_ready;
    logic                     r_busy;
    logic [2:0]               r_wave;
    logic [ERR_CNT_W-1:0]     r_err;
    logic [16*NUM_VOICES-1:0] r_freq;
    logic [8*NUM_VOICES-1:0]  r_env;
    logic [NUM_VOICES-1:0]    r_freq_upd;
    logic [NUM_VOICES-1:0]    r_env_upd;

    logic                 w_nss;
    logic                 w_nss_rise;
    logic                 w_nss_fall;
    logic                 w_take;
    logic                 w_voice_ok;
    logic [ERR_CNT_W-1:0] w_err_inc;
    logic [3:0]           w_op;

    sync_2ff #(.RST_VAL(1'b1)) u_nss_sync (
        .clk     (clk),
        .nreset  (nreset),
        .i_async (spi_nss),
        .o_sync  (w_nss)
    );

    assign w_nss_rise = w_nss & ~r_nss_d;
    assign w_nss_fall = ~w_nss & r_nss_d;
    assign w_take     = rx_valid & r_rx_ready;
    assign w_voice_ok = int'(r_voice) < NUM_VOICES;
    assign w_err_inc  = (&r_err) ? r_err : r_err + 1'b1;
    assign w_op       = rx_data[7:4];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= IDLE;
            r_op       <= OP_NOP;
            r_voice    <= '0;
            r_hi       <= '0;
            r_nss_d    <= 1'b1;
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_wave     <= WAVE_SEL_RESET;
            r_err      <= '0;
            r_freq     <= '0;
            r_env      <= '0;
            r_freq_upd <= '0;
            r_env_upd  <= '0;
        end else begin
            r_nss_d    <= w_nss;
            r_rx_ready <= 1'b1;
            r_freq_upd <= '0;
            r_env_upd  <= '0;
            // frame edges win over any byte arriving in the same cycle
            if (w_nss_fall) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if (w_nss_rise) begin
                if (r_state != IDLE) begin
                    r_err <= w_err_inc;
                end
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else if (w_take) begin
                unique case (r_state)
                    IDLE: begin
                        if (rx_data[3] || !op_valid(w_op)) begin
                            r_err <= w_err_inc;
                        end else if (pay_len(w_op) != PAY_LEN_NOP) begin
                            r_op    <= w_op;
                            r_voice <= rx_data[2:0];
                            r_state <= PAY1;
                            r_busy  <= 1'b1;
                        end
                    end
                    PAY1: begin
                        if (r_op == OP_SET_FREQ) begin
                            r_hi    <= rx_data;
                            r_state <= PAY2;
                        end else begin
                            if (r_op == OP_SET_WAVE) begin
                                r_wave <= rx_data[2:0];
                            end else if (!w_voice_ok) begin
                                r_err <= w_err_inc;
                            end else begin
                                for (int v = 0; v < NUM_VOICES; v++) begin
                                    if (r_voice == 3'(v)) begin
                                        r_env[8*v +: 8] <= rx_data;
                                        r_env_upd[v]    <= 1'b1;
                                    end
                                end
                            end
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    PAY2: begin
                        if (!w_voice_ok) begin
                            r_err <= w_err_inc;
                        end else begin
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (r_voice == 3'(v)) begin
                                    r_freq[16*v +: 16] <= {r_hi, rx_data};
                                    r_freq_upd[v]      <= 1'b1;
                                end
                            end
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_ready = r_rx_ready;
    assign freq_bus = r_freq;
    assign env_bus  = r_env;
    assign wave_sel = r_wave;
    assign freq_upd = r_freq_upd;
    assign env_upd  = r_env_upd;
    assign err_cnt  = r_err;
    assign busy     = r_busy;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: an 8-voice and a 4-voice
// instance share stimulus; expected values are hand-computed.
module tb_spi_cmd_decoder;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        spi_nss = 1'b1;

    logic        rx_ready;
    logic [127:0] freq_bus;
    logic [63:0] env_bus;
    logic [2:0]  wave_sel;
    logic [7:0]  freq_upd;
    logic [7:0]  env_upd;
    logic [7:0]  err_cnt;
    logic        busy;

    logic        rx_ready4;
    logic [63:0] freq_bus4;
    logic [31:0] env_bus4;
    logic [2:0]  wave_sel4;
    logic [3:0]  freq_upd4;
    logic [3:0]  env_upd4;
    logic [7:0]  err_cnt4;
    logic        busy4;

    int checks = 0;
    int errors = 0;
    logic [7:0] seen;

    always #5 clk = ~clk;

    spi_cmd_decoder #(.NUM_VOICES(8)) dut (
        .clk(clk), .nreset(nreset), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .spi_nss(spi_nss),
        .freq_bus(freq_bus), .env_bus(env_bus), .wave_sel(wave_sel),
        .freq_upd(freq_upd), .env_upd(env_upd), .err_cnt(err_cnt),
        .busy(busy)
    );

    spi_cmd_decoder #(.NUM_VOICES(4)) dut4 (
        .clk(clk), .nreset(nreset), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready4), .spi_nss(spi_nss),
        .freq_bus(freq_bus4), .env_bus(env_bus4), .wave_sel(wave_sel4),
        .freq_upd(freq_upd4), .env_upd(env_upd4), .err_cnt(err_cnt4),
        .busy(busy4)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", rx_ready, 0);
        chk("rst_busy", busy, 0);
        nreset = 1'b1;
        tick();
        chk("ready_after_release", rx_ready, 1);
        chk("rst_freq", freq_bus, 0);
        chk("rst_env", env_bus, 0);
        chk("rst_wave", wave_sel, 1);
        chk("rst_err", err_cnt, 0);

        // freq write voice 3
        spi_nss = 1'b0;
        settle();
        put(8'h13);
        chk("busy_cmd", busy, 1);
        put(8'h12);
        put(8'h34);
        chk("freq_v3", freq_bus[63:48], 16'h1234);
        chk("freq_others", {freq_bus[127:64], freq_bus[47:0]}, 0);
        chk("freq_upd_pulse", freq_upd, 8'h08);
        chk("busy_commit", busy, 0);
        tick();
        chk("freq_upd_clear", freq_upd, 0);

        // back-to-back env + wave
        rx_valid = 1'b1; rx_data = 8'h25; tick();
        rx_data = 8'h80; tick();
        chk("env_v5", env_bus[47:40], 8'h80);
        chk("env_upd_pulse", env_upd, 8'h20);
        rx_data = 8'h30; tick();
        chk("env_upd_clear", env_upd, 0);
        rx_data = 8'h04; tick();
        rx_valid = 1'b0;
        chk("wave_sel", wave_sel, 3'd4);
        chk("err_b2b", err_cnt, 0);
        chk("env_other", {env_bus[63:48], env_bus[39:0]}, 0);

        // abort in PAY2
        put(8'h11);
        put(8'hAB);
        chk("busy_pay2", busy, 1);
        spi_nss = 1'b1;
        seen = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | freq_upd;
        end
        chk("abort_no_upd", seen, 0);
        chk("abort_freq_v1", freq_bus[31:16], 0);
        chk("abort_err", err_cnt, 1);
        chk("abort_busy", busy, 0);
        spi_nss = 1'b0;
        settle();
        put(8'h10);
        put(8'h00);
        put(8'h10);
        chk("freq_v0", freq_bus[15:0], 16'h0010);
        chk("freq_v3_hold", freq_bus[63:48], 16'h1234);

        // errors, out-of-range voice, resync
        nreset = 1'b0;
        tick();
        nreset = 1'b1;
        settle();
        put(8'h70);
        put(8'h18);
        chk("err_bad_cmds", err_cnt, 2);
        put(8'h26);
        put(8'h55);
        chk("err8", err_cnt, 2);
        chk("env8_v6", env_bus[55:48], 8'h55);
        chk("err4_range", err_cnt4, 3);
        chk("env4_unchanged", env_bus4, 0);
        chk("env4_no_upd", env_upd4, 0);
        put(8'h00);
        put(8'h21);
        put(8'h66);
        chk("env4_resync", env_bus4[15:8], 8'h66);
        chk("err4_after_nop", err_cnt4, 3);
        chk("env8_v1", env_bus[15:8], 8'h66);

        // saturation
        rx_valid = 1'b1;
        rx_data  = 8'hF0;
        for (int i = 0; i < 300; i++) tick();
        rx_valid = 1'b0;
        chk("err_sat", err_cnt, 8'hFF);
        chk("err4_sat", err_cnt4, 8'hFF);

        // async reset mid PAY2
        put(8'h13);
        put(8'h12);
        chk("busy_pre_rst", busy, 1);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_freq", freq_bus, 0);
        chk("arst_env", env_bus, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_wave", wave_sel, 1);
        chk("arst_ready", rx_ready, 0);
        tick();
        nreset = 1'b1;
        tick();
        chk("rerelease_ready", rx_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Parses the MOSI byte stream from spi_slave into per-voice synthesis controls: a 16-bit phase increment, an 8-bit envelope level, and a global waveform select. It sits directly upstream of dds, in place of the ad-hoc byte counting done in the datapath. It presents stable, fully assembled registers and one-cycle update strobes, all in the clk domain. Partial or malformed SPI frames never corrupt the outputs.

Parameters:
NUM_VOICES, 8, number of voices addressable (1..8)
WAVE_SEL_RESET, 1, reset value of wave_sel
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock (same clk as dds/spi_slave sysclk)
nreset  in  1  asynchronous, active-low reset
rx_valid  in  1  spi_slave stsourcevalid; one byte per high cycle
rx_data  in  8  spi_slave stsourcedata
rx_ready  out  1  spi_slave stsourceready; tied high except during reset
spi_nss  in  1  raw chip select (asynchronous to clk), low = frame active
freq_bus  out  16*NUM_VOICES  phase increments, voice v at [16v+15:16v]
env_bus  out  8*NUM_VOICES  envelope levels, voice v at [8v+7:8v]
wave_sel  out  3  waveform mux select
freq_upd  out  NUM_VOICES  one-cycle pulse on the freq write of voice v
env_upd  out  NUM_VOICES  one-cycle pulse on the env write of voice v
err_cnt  out  ERR_CNT_W  saturating count of rejected/aborted commands
busy  out  1  high while a command is partially received

Behaviour:
- Reset (nreset low, asynchronous): the following all clear to 0 — freq_bus, env_bus, freq_upd, env_upd, err_cnt, busy, rx_ready, and the state (IDLE). wave_sel resets to WAVE_SEL_RESET. rx_ready goes to 1 on the first clk after release.
- spi_nss passes through a 2-flop synchronizer (reset to 1, i.e. idle). All edge detection uses the synchronized value.
- Command byte format:
  - [7:4] opcode.
  - [3] reserved; must be 0.
  - [2:0] voice index.
- Opcodes and payload (all multi-byte payloads MSB first):
  - 0x1 SET_FREQ: 2 payload bytes.
  - 0x2 SET_ENV: 1 payload byte.
  - 0x3 SET_WAVE: 1 payload byte; uses payload[2:0]; voice field ignored.
  - 0x0 NOP: 0 payload bytes.
- Any other opcode, or reserved bit set:
  - The command byte is consumed.
  - err_cnt increments.
  - The decoder stays in IDLE, so the next byte is treated as a new command.
- States:
  - IDLE: a byte is accepted when rx_valid is high. On a valid opcode with payload, go to PAY1, latch opcode/voice, set busy.
  - PAY1: SET_FREQ latches the high byte and goes to PAY2. SET_ENV and SET_WAVE commit and go to IDLE.
  - PAY2: SET_FREQ commits {hi,lo} and goes to IDLE.
- Commit rules:
  - Registers update on the clk edge that accepts the final byte.
  - The matching upd bit is high for exactly the following cycle. Latency from the final rx_valid to the new value is 1 cycle.
  - busy drops at the commit edge.
- Voice index >= NUM_VOICES:
  - The payload is still consumed.
  - No register write and no upd pulse.
  - err_cnt increments at commit time.
- Frame boundaries:
  - A rising edge of synchronized nss while in PAY1 or PAY2 aborts: return to IDLE, discard the partial data, err_cnt increments, no write.
  - A falling edge of nss always forces IDLE without counting an error, so each frame starts on a command byte.
- Simultaneous events:
  - An nss edge takes priority over an rx_valid in the same cycle; that byte is dropped.
  - For back-to-back commands, rx_valid may be high on consecutive cycles; every byte is processed with no bubble.
- err_cnt saturates at all-ones.
- Unwritten voices hold their value indefinitely.

Decomposition:
- dds_pkg holds:
  - opcode localparams OP_NOP/OP_SET_FREQ/OP_SET_ENV/OP_SET_WAVE;
  - the state encoding IDLE/PAY1/PAY2;
  - payload length constants.
- One sub-module: sync_2ff, a 2-flop synchronizer with parameterised reset value, used for spi_nss. It is reusable for other async inputs.

Test Plan:
- Reset release: freq_bus=0, env_bus=0, wave_sel=1, err_cnt=0; rx_ready=1 one cycle after release.
- nss low, bytes 0x13,0x12,0x34 -> freq_bus[63:48]=0x1234 one cycle after the third byte; freq_upd=8'b0000_1000 for exactly 1 cycle; other voices unchanged.
- Back-to-back 0x25,0x80,0x30,0x04 on consecutive cycles -> env voice5=0x80 with env_upd[5] pulse; wave_sel=4; err_cnt=0.
- 0x11,0xAB then nss rises -> no freq change, no upd pulse, err_cnt=1, busy=0; the next frame 0x10,0x00,0x10 writes voice0=0x0010.
- Bytes 0x70, 0x18 (reserved bit), then with NUM_VOICES=4 0x26,0x55 -> err_cnt=3, env_bus unchanged, and the decoder resynchronizes on the following 0x00 NOP.
- 300 invalid 0xF0 bytes -> err_cnt saturates at 0xFF with no wrap; asserting nreset mid-PAY2 clears state and outputs immediately.
